// File: rtl/bpm_pkg.sv
// Shared types and constants for the beat-to-tempo estimator.
package bpm_pkg;

  localparam int IVL_W  = 12;  // millisecond interval counter width
  localparam int BPM_W  = 9;   // tempo estimate width
  localparam int DIVD_W = 16;  // divider dividend width

  // One minute in milliseconds: BPM = 60000 / interval_ms.
  localparam logic [DIVD_W-1:0] BPM_DIVIDEND = 16'd60000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVIDE  = 2'd1,
    ST_AVERAGE = 2'd2
  } bpm_state_t;

  // Exponential smoothing with weight 3/4 on the old estimate, floor division.
  // 3*240 + 240 = 960 fits comfortably in the 11-bit intermediate.
  function automatic logic [BPM_W-1:0] smooth_bpm(input logic [BPM_W-1:0] est,
                                                  input logic [BPM_W-1:0] q);
    logic [10:0] sum;
    sum = {2'b00, est} + {2'b00, est} + {2'b00, est} + {2'b00, q};
    return sum[10:2];
  endfunction

endpackage

// File: rtl/bpm_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// start loads the operands; the next 16 cycles each retire one bit.
// done is high during the final iteration cycle, so the quotient is
// valid from the following cycle onward and holds until the next start.
module bpm_divider
  import bpm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIVD_W-1:0] dividend,
  input  logic [IVL_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic [BPM_W-1:0]  quotient
);

  logic [4:0]        count;
  logic [DIVD_W-1:0] quo_sh;   // dividend shifts out the top, quotient bits shift in
  logic [IVL_W:0]    rem;
  logic [IVL_W-1:0]  dsor;
  logic [IVL_W:0]    trial;
  logic [IVL_W:0]    diff;
  logic              fits;

  // Trial subtraction for the current iteration.
  always_comb begin
    trial = {rem[IVL_W-1:0], quo_sh[DIVD_W-1]};
    diff  = trial - {1'b0, dsor};
    fits  = (trial >= {1'b0, dsor});
  end

  // Operand load and one restoring step per cycle while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 5'd0;
      quo_sh <= 16'd0;
      rem    <= 13'd0;
      dsor   <= 12'd0;
    end else if (start) begin
      count  <= 5'd16;
      quo_sh <= dividend;
      rem    <= 13'd0;
      dsor   <= divisor;
    end else if (count != 5'd0) begin
      count  <= count - 5'd1;
      quo_sh <= {quo_sh[DIVD_W-2:0], fits};
      rem    <= fits ? diff : trial;
    end else begin
      count  <= count;
      quo_sh <= quo_sh;
      rem    <= rem;
      dsor   <= dsor;
    end
  end

  assign busy     = (count != 5'd0);
  assign done     = (count == 5'd1);
  assign quotient = quo_sh[BPM_W-1:0];

endmodule

// File: rtl/bpm_estimator.sv
// Tempo estimator: measures the spacing of accepted onset strobes in
// milliseconds, converts it to BPM with an iterative divider and keeps a
// smoothed estimate. Also emits beat / downbeat strobes for the display.
module bpm_estimator
  import bpm_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int MIN_IVL_MS = 250,
  parameter int MAX_IVL_MS = 1500,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat_in,
  output logic [1:0]       beat_pulse,
  output logic [BPM_W-1:0] bpm_estimate
);

  localparam int unsigned     TICK_DIV  = CLK_HZ / 1000;
  localparam logic [31:0]     TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [IVL_W-1:0] MIN_IVL  = IVL_W'(MIN_IVL_MS);
  localparam logic [IVL_W-1:0] MAX_IVL  = IVL_W'(MAX_IVL_MS);
  localparam logic [IVL_W-1:0] TMO_LAST = IVL_W'(TIMEOUT_MS - 1);
  localparam logic [IVL_W-1:0] IVL_SAT  = {IVL_W{1'b1}};

  bpm_state_t       state;
  bpm_state_t       next_state;
  logic [31:0]      presc;
  logic             tick;
  logic [IVL_W-1:0] ivl_ms;
  logic             have_prev;
  logic [1:0]       beat_idx;
  logic             accept;
  logic             in_range;
  logic             timeout;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [BPM_W-1:0] quotient;

  // Millisecond prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= 32'd0;
    end else if (tick) begin
      presc <= 32'd0;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  assign tick = (presc == TICK_LAST);

  // Beat qualification and timeout detection.
  always_comb begin
    accept   = 1'b0;
    in_range = 1'b0;
    timeout  = 1'b0;
    if ((state == ST_IDLE) && beat_in) begin
      if (have_prev && (ivl_ms < MIN_IVL)) begin
        accept = 1'b0;
      end else begin
        accept = 1'b1;
      end
    end else begin
      accept = 1'b0;
    end
    in_range = accept && have_prev && (ivl_ms >= MIN_IVL) && (ivl_ms <= MAX_IVL);
    // Fires on the tick that brings ivl_ms up to the timeout value; a
    // coincident accepted beat restarts the interval instead.
    timeout  = tick && (ivl_ms == TMO_LAST) && !accept;
  end

  // Interval counter. A tick landing on the accepting edge is the first
  // millisecond of the new interval, so the count reads N exactly N ms
  // after the beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      ivl_ms <= 12'd0;
    end else if (accept) begin
      ivl_ms <= tick ? 12'd1 : 12'd0;
    end else if (tick && (ivl_ms != IVL_SAT)) begin
      ivl_ms <= ivl_ms + 12'd1;
    end else begin
      ivl_ms <= ivl_ms;
    end
  end

  // Beat bookkeeping and registered beat / downbeat strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_prev  <= 1'b0;
      beat_idx   <= 2'd0;
      beat_pulse <= 2'b00;
    end else if (accept) begin
      have_prev  <= 1'b1;
      beat_idx   <= beat_idx + 2'd1;
      beat_pulse <= {(beat_idx == 2'd0), 1'b1};
    end else if (timeout) begin
      have_prev  <= 1'b0;
      beat_idx   <= 2'd0;
      beat_pulse <= 2'b00;
    end else begin
      have_prev  <= have_prev;
      beat_idx   <= beat_idx;
      beat_pulse <= 2'b00;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state and divider launch.
  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_range) begin
          next_state = ST_DIVIDE;
          div_start  = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          next_state = ST_AVERAGE;
        end else if (div_busy) begin
          next_state = ST_DIVIDE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_AVERAGE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Smoothed estimate: first valid quotient loads directly, later ones blend in.
  always_ff @(posedge clk) begin
    if (reset) begin
      bpm_estimate <= 9'd0;
    end else if (state == ST_AVERAGE) begin
      if (bpm_estimate == 9'd0) begin
        bpm_estimate <= quotient;
      end else begin
        bpm_estimate <= smooth_bpm(bpm_estimate, quotient);
      end
    end else if (timeout) begin
      bpm_estimate <= 9'd0;
    end else begin
      bpm_estimate <= bpm_estimate;
    end
  end

  bpm_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (BPM_DIVIDEND),
    .divisor  (ivl_ms),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

endmodule

// File: doc/bpm_estimator.md
BPM_ESTIMATOR -- requirements
Module: bpm_estimator

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency used to derive the 1 ms tick.
REQ-002 Parameter MIN_IVL_MS, default 250, shortest accepted beat interval (240 BPM).
REQ-003 Parameter MAX_IVL_MS, default 1500, longest interval that updates the estimate (40 BPM).
REQ-004 Parameter TIMEOUT_MS, default 3000, silence after which the estimate is cleared.
REQ-005 clk  input  1  system clock; one clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 beat_in  input  1  one-cycle onset strobe from the audio onset detector.
REQ-008 beat_pulse  output  2  [0] one-cycle accepted-beat strobe; [1] one-cycle downbeat strobe on every 4th accepted beat; feeds the vga display stage.
REQ-009 bpm_estimate  output  9  smoothed tempo in BPM, unsigned; 0 = no estimate.

Function
REQ-010 A 1 ms tick SHALL be generated by a prescaler counting CLK_HZ/1000 cycles.
REQ-011 Interval counter ivl_ms (12 bit) SHALL increment on each tick, saturate at 4095, and clear to 0 on every accepted beat.
REQ-012 Flag have_prev SHALL be 0 after reset or timeout and set on any accepted beat.
REQ-013 beat_in with have_prev=1 and ivl_ms < MIN_IVL_MS SHALL be rejected: no pulse, no counter clear, no state change.
REQ-014 Any other beat_in seen in IDLE SHALL be accepted; beat_pulse[0] asserts for exactly one cycle, the cycle after beat_in.
REQ-015 Beat index (2 bit, mod 4) SHALL increment per accepted beat; beat_pulse[1] asserts in the same cycle as beat_pulse[0] when the index was 0 before incrementing (1st, 5th, 9th... beat).
REQ-016 FSM states: IDLE, DIVIDE, AVERAGE.
REQ-017 IDLE -> DIVIDE on an accepted beat with have_prev=1 and MIN_IVL_MS <= ivl_ms <= MAX_IVL_MS; latched interval becomes the divisor, 60000 the dividend.
REQ-018 Accepted beats failing the REQ-017 range (first beat, or ivl_ms > MAX_IVL_MS) SHALL pulse but stay in IDLE with no estimate update.
REQ-019 DIVIDE SHALL run a 16-iteration restoring unsigned divide, one bit per cycle, then -> AVERAGE; quotient in 40..240 fits 9 bits.
REQ-020 AVERAGE: if bpm_estimate==0 load quotient; else bpm_estimate <= floor((3*bpm_estimate + quotient)/4) using 11-bit intermediate; -> IDLE.
REQ-021 bpm_estimate SHALL update exactly 18 cycles after the beat_in cycle.
REQ-022 beat_in arriving in DIVIDE or AVERAGE SHALL be ignored entirely.
REQ-023 When ivl_ms reaches TIMEOUT_MS: bpm_estimate <= 0, beat index <= 0, have_prev <= 0; no pulse.
REQ-024 Timeout coinciding with an accepted beat: beat wins (counter clears, no timeout action).

Reset
REQ-025 On reset: beat_pulse=2'b00, bpm_estimate=0, ivl_ms=0, prescaler=0, beat index=0, have_prev=0, FSM=IDLE, divider cleared.
REQ-026 Reset asserted mid-DIVIDE or mid-AVERAGE SHALL abort the operation with no estimate update after reset release.

Structure
REQ-027 Package bpm_pkg SHALL hold the FSM state enum, dividend constant 60000, and widths (IVL_W=12, BPM_W=9).
REQ-028 The iterative divider SHALL be sub-module bpm_divider (start/busy/done, 16-bit dividend, 12-bit divisor, 9-bit quotient).

Verification (CLK_HZ=1000 so 1 tick = 1 cycle)
REQ-029 Reset, beats at t=0,500,1000 -> pulse[0] each beat; pulse[1] at t=0; bpm_estimate 0 until t=518, then 120, still 120 after t=1018.
REQ-030 From 120, beats every 400 -> next update 127 (floor(510/4)), then 132.
REQ-031 Beat 100 after accepted beat -> no pulse, estimate unchanged; following beat at 500 from original -> accepted, 120.
REQ-032 No beat for 3000 after last beat -> bpm_estimate=0 at t_last+3000; next beat pulses[1:0]=2'b11, no estimate update.
REQ-033 Interval 1600 -> pulse only, estimate unchanged; intervals 250 and 1500 -> quotients 240 and 40.
REQ-034 reset asserted 5 cycles into DIVIDE -> all outputs 0 next cycle, no later update without new beats.
